// File: rtl/stream_endpoint_pkg.sv
// Shared constants and types for stream_endpoint.
// The CRC constants are only consumed when STREAM_ENDPOINT_CRC_EN is defined.
package stream_endpoint_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef struct packed {
        logic do_write;
        logic do_read;
        logic ovf_evt;
        logic udf_evt;
    } xfer_t;

endpackage

// File: rtl/crc32_byte_update.sv
// Combinational reflected CRC-32 update of one byte (LSB-first, polynomial from the package).
module crc32_byte_update
    import stream_endpoint_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/stream_endpoint.sv
// Single-clock buffered stream endpoint with sticky overflow/underflow flags.
// Define STREAM_ENDPOINT_CRC_EN to add a CRC-32 over accepted write words (DATA_WIDTH must be 8).
module stream_endpoint
    import stream_endpoint_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow,
`ifdef STREAM_ENDPOINT_CRC_EN
    input  logic                  crc_clear,
    output logic [31:0]           crc_out,
`endif
    input  logic                  clear_flags
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    xfer_t                 x;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        x          = '0;
        x.do_read  = read_enable && !empty;
        // A read on the same edge frees a slot, so a write to a full buffer still lands.
        x.do_write = write_enable && (!full || x.do_read);
        x.ovf_evt  = write_enable && !x.do_write;
        x.udf_evt  = read_enable && empty;

        wr_ptr_d    = x.do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = x.do_read  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        read_data_d = x.do_read  ? mem_q[rd_ptr_q] : read_data_q;
        count_d     = count_q;
        if (x.do_write && !x.do_read) count_d = count_q + 1'b1;
        if (x.do_read && !x.do_write) count_d = count_q - 1'b1;

        overflow_d  = (overflow_q  && !clear_flags) || x.ovf_evt;
        underflow_d = (underflow_q && !clear_flags) || x.udf_evt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            read_data_q <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            read_data_q <= read_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: pointers and count decide what is valid.
    always_ff @(posedge clock) begin
        if (x.do_write) mem_q[wr_ptr_q] <= write_data;
    end

    assign read_data = read_data_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef STREAM_ENDPOINT_CRC_EN
    logic [31:0] crc_q, crc_d, crc_next;

    crc32_byte_update u_crc (
        .crc_in  (crc_q),
        .data_in (write_data),
        .crc_out (crc_next)
    );

    always_comb begin
        crc_d = crc_q;
        if (crc_clear)       crc_d = CRC_INIT;
        else if (x.do_write) crc_d = crc_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) crc_q <= CRC_INIT;
        else       crc_q <= crc_d;
    end

    assign crc_out = ~crc_q;
`endif

endmodule

// File: tb/tb_stream_endpoint.sv
// Directed self-checking bench for stream_endpoint (DATA_WIDTH=8, ADDR_WIDTH=4).
module tb_stream_endpoint;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] write_data = '0;
    logic       write_enable = 1'b0;
    logic       read_enable = 1'b0;
    logic       clear_flags = 1'b0;
    logic [7:0] read_data;
    logic [4:0] count;
    logic       full, empty, overflow, underflow;
`ifdef STREAM_ENDPOINT_CRC_EN
    logic        crc_clear = 1'b0;
    logic [31:0] crc_out;
`endif

    int n_chk = 0;
    int n_err = 0;

    stream_endpoint #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .write_data   (write_data),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .underflow    (underflow),
`ifdef STREAM_ENDPOINT_CRC_EN
        .crc_clear    (crc_clear),
        .crc_out      (crc_out),
`endif
        .clear_flags  (clear_flags)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge with the given strobes; returns at posedge+1 with strobes dropped.
    task automatic cyc(input logic we, input logic [7:0] wd, input logic re, input logic cf);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        clear_flags  = cf;
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear_flags  = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rdata", 32'(read_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Two words in, two out in order
        cyc(1, 8'hA5, 0, 0);
        cyc(1, 8'h3C, 0, 0);
        chk("two_count", 32'(count), 2);
        cyc(0, 0, 1, 0);
        chk("rd1_data", 32'(read_data), 32'hA5);
        chk("rd1_count", 32'(count), 1);
        cyc(0, 0, 1, 0);
        chk("rd2_data", 32'(read_data), 32'h3C);
        chk("rd2_count", 32'(count), 0);
        chk("rd2_empty", 32'(empty), 1);

        // Fill to 16, then one more write is dropped
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf0", 32'(overflow), 0);
        cyc(1, 8'h10, 0, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_full", 32'(full), 1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("drain%0d", i), 32'(read_data), 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);
        cyc(0, 0, 0, 1);
        chk("ovf_clr", 32'(overflow), 0);

        // Underflow holds read_data
        cyc(0, 0, 1, 0);
        chk("udf_set", 32'(underflow), 1);
        chk("udf_hold", 32'(read_data), 32'h0F);
        chk("udf_count", 32'(count), 0);
        cyc(0, 0, 0, 1);
        chk("udf_clr", 32'(underflow), 0);

        // Simultaneous read+write while full
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0);
        cyc(1, 8'h99, 1, 0);
        chk("rw_full_data", 32'(read_data), 32'h20);
        chk("rw_full_count", 32'(count), 16);
        chk("rw_full_ovf", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("rw_drain%0d", i), 32'(read_data), (i < 15) ? 32'(8'h21 + i) : 32'h99);
        end

        // Simultaneous read+write while empty: write lands, underflow flagged
        cyc(1, 8'h77, 1, 0);
        chk("rw_empty_count", 32'(count), 1);
        chk("rw_empty_udf", 32'(underflow), 1);
        chk("rw_empty_hold", 32'(read_data), 32'h99);
        cyc(0, 0, 1, 1);
        chk("rw_empty_rd", 32'(read_data), 32'h77);
        chk("rw_empty_clr", 32'(underflow), 0);

        // Clear coinciding with a new underflow: set wins
        cyc(0, 0, 1, 1);
        chk("set_wins", 32'(underflow), 1);
        cyc(0, 0, 0, 1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0, 0);
        chk("pre_rst_count", 32'(count), 5);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        write_enable = 1'b1;
        write_data   = 8'hEE;
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        chk("rst_ignores_wr", 32'(count), 0);
        chk("rst_rdata0", 32'(read_data), 0);
        reset = 1'b0;
        cyc(0, 0, 1, 0);
        chk("post_rst_udf", 32'(underflow), 1);
        chk("post_rst_rdata", 32'(read_data), 0);

`ifdef STREAM_ENDPOINT_CRC_EN
        begin
            logic [71:0] msg;
            msg = "123456789";
            crc_clear = 1'b1;
            cyc(0, 0, 0, 0);
            crc_clear = 1'b0;
            for (int i = 8; i >= 0; i--) cyc(1, msg[i*8 +: 8], 0, 0);
            chk("crc_check", crc_out, 32'hCBF43926);
            crc_clear = 1'b1;
            cyc(1, 8'h41, 0, 0);
            crc_clear = 1'b0;
            chk("crc_clear", crc_out, 32'h00000000);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
